// File: rtl/crop_window.sv
// crop_window: crops a WIN_W x WIN_H window out of a raster pixel stream, top line latched per frame.
// Define CROP_BORDER_EN to paint the window outline with 10'h3FF.
module crop_window #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_START  = 160,
    parameter int WIN_W    = 320,
    parameter int WIN_H    = 240
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    input  logic [15:0] iYSTART,
    output logic        oDVAL,
    output logic [9:0]  oDATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oFRAME_DONE
);
    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] YS_MAX = 16'(V_ACTIVE - WIN_H);
    localparam logic [15:0] X_LO   = 16'(X_START);
    localparam logic [15:0] X_HI   = 16'(X_START + WIN_W - 1);
    localparam logic [15:0] W_LAST = 16'(WIN_W - 1);
    localparam logic [15:0] H_LAST = 16'(WIN_H - 1);

    typedef enum logic [1:0] {S_WAIT, S_CROP, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_x, r_y, r_ys;
    logic [15:0] w_ys, w_ox, w_oy;
    logic        w_origin, w_in, w_first, w_last, w_fend;
    logic [9:0]  w_data;

    // The (0,0) pixel already uses the freshly clamped start line.
    assign w_origin = iDVAL && r_x == 16'd0 && r_y == 16'd0;
    assign w_ys     = w_origin ? (iYSTART > YS_MAX ? YS_MAX : iYSTART) : r_ys;
    assign w_ox     = r_x - X_LO;
    assign w_oy     = r_y - w_ys;
    assign w_in     = iDVAL && r_state != S_DONE && r_x >= X_LO && r_x <= X_HI
                      && r_y >= w_ys && w_oy <= H_LAST;
    assign w_first  = w_in && w_ox == 16'd0 && w_oy == 16'd0;
    assign w_last   = w_in && w_ox == W_LAST && w_oy == H_LAST;
    assign w_fend   = iDVAL && r_x == X_LAST && r_y == Y_LAST;

`ifdef CROP_BORDER_EN
    assign w_data = (w_ox == 16'd0 || w_ox == W_LAST || w_oy == 16'd0 || w_oy == H_LAST) ? 10'h3FF : iDATA;
`else
    assign w_data = iDATA;
`endif

    // A window ending on the frame's last pixel skips S_DONE so the next frame is not blocked.
    always_comb begin
        w_next = r_state;
        if (r_state == S_DONE)
            w_next = w_fend ? S_WAIT : S_DONE;
        else if (w_last)
            w_next = w_fend ? S_WAIT : S_DONE;
        else if (w_first)
            w_next = S_CROP;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state     <= S_WAIT;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_ys        <= 16'd0;
            oDVAL       <= 1'b0;
            oDATA       <= 10'd0;
            oX          <= 16'd0;
            oY          <= 16'd0;
            oFRAME_DONE <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ys        <= w_ys;
            oDVAL       <= w_in;
            oFRAME_DONE <= w_last;
            if (iDVAL) begin
                r_x <= r_x == X_LAST ? 16'd0 : r_x + 16'd1;
                r_y <= r_x != X_LAST ? r_y : (r_y == Y_LAST ? 16'd0 : r_y + 16'd1);
            end
            if (w_in) begin
                oDATA <= w_data;
                oX    <= w_ox;
                oY    <= w_oy;
            end
        end
    end
endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window: directed frames on a shrunken 16x12 raster with a 6x5 window starting at column 4.
module tb_crop_window;
    localparam int H  = 16;
    localparam int V  = 12;
    localparam int XS = 4;
    localparam int WW = 6;
    localparam int WH = 5;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iDVAL;
    logic [9:0]  iDATA;
    logic [15:0] iYSTART;
    logic        oDVAL;
    logic [9:0]  oDATA;
    logic [15:0] oX;
    logic [15:0] oY;
    logic        oFRAME_DONE;

    int n_pass = 0, n_chk = 0;
    int n_out, n_done, seq_err, fx, fy, dx, dy;

    crop_window #(.H_ACTIVE(H), .V_ACTIVE(V), .X_START(XS), .WIN_W(WW), .WIN_H(WH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA), .iYSTART(iYSTART),
        .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY), .oFRAME_DONE(oFRAME_DONE)
    );

    always #5 iCLK = ~iCLK;

    // Drives one frame from (0,0); ys0 is offered at (0,0), ys1 on every other cycle.
    // Stops before presenting raster index stop (-1 = run the whole frame).
    task automatic run_frame(input int ys0, input int ys1, input bit gaps, input bit cdata, input int stop);
        int tx = 0, ty = 0, ph = 0, ys, ex, ey, exd;
        bit v, have = 0;
        logic [15:0] lx = 0, ly = 0;
        logic [9:0] pix;
        ys = ys0 > V - WH ? V - WH : ys0;
        n_out = 0; n_done = 0; seq_err = 0; fx = -1; fy = -1; dx = -1; dy = -1;
        forever begin
            if (ty * H + tx == stop) return;
            v = gaps ? (ph == 0) : 1'b1;
            ph = 1 - ph;
            pix = cdata ? 10'h055 : 10'(tx * 37 + ty * 11 + 5);
            iDVAL = v;
            iDATA = pix;
            iYSTART = (tx == 0 && ty == 0) ? 16'(ys0) : 16'(ys1);
            @(posedge iCLK);
            #1;
            if (v && tx >= XS && tx < XS + WW && ty >= ys && ty < ys + WH) begin
                ex = tx - XS;
                ey = ty - ys;
                exd = int'(pix);
`ifdef CROP_BORDER_EN
                if (ex == 0 || ex == WW - 1 || ey == 0 || ey == WH - 1) exd = 'h3FF;
`endif
                n_out++;
                if (fx < 0) begin fx = tx; fy = ty; end
                if (oDVAL !== 1'b1 || oX !== 16'(ex) || oY !== 16'(ey) || oDATA !== 10'(exd)) seq_err++;
                if (oFRAME_DONE !== (ex == WW - 1 && ey == WH - 1)) seq_err++;
                lx = 16'(ex); ly = 16'(ey); have = 1;
            end else if (oDVAL !== 1'b0 || oFRAME_DONE !== 1'b0 || (have && (oX !== lx || oY !== ly))) seq_err++;
            if (oFRAME_DONE === 1'b1) begin n_done++; dx = tx; dy = ty; end
            if (v) begin
                if (tx == H - 1) begin
                    tx = 0;
                    if (ty == V - 1) return;
                    ty++;
                end else tx++;
            end
        end
    endtask

    task automatic test_reset();
        iRST = 1'b0; iDVAL = 1'b0; iDATA = 10'h3A5; iYSTART = 16'd3;
        @(posedge iCLK); #1;
        n_chk++; if ({oDVAL, oFRAME_DONE} !== 2'b00) $display("FAIL reset_ctrl: got %b want 00", {oDVAL, oFRAME_DONE}); else n_pass++;
        n_chk++; if ({oDATA, oX, oY} !== 42'd0) $display("FAIL reset_data: got %h/%0d/%0d want 0/0/0", oDATA, oX, oY); else n_pass++;
        #2 iRST = 1'b1;
    endtask

    task automatic test_full_frame();
        run_frame(3, 3, 1'b0, 1'b0, -1);
        n_chk++; if (n_out != WW * WH || n_done != 1) $display("FAIL full_counts: got %0d outs %0d dones want 30 1", n_out, n_done); else n_pass++;
        n_chk++; if (seq_err != 0) $display("FAIL full_seq: got %0d errors want 0", seq_err); else n_pass++;
        n_chk++; if (fx != 4 || fy != 3) $display("FAIL full_first: got (%0d,%0d) want (4,3)", fx, fy); else n_pass++;
        n_chk++; if (dx != 9 || dy != 7) $display("FAIL full_done: got (%0d,%0d) want (9,7)", dx, dy); else n_pass++;
    endtask

    task automatic test_ystart_bounds();
        run_frame(10, 10, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 7 || dy != 11) $display("FAIL clamp_lines: got %0d..%0d want 7..11", fy, dy); else n_pass++;
        n_chk++; if (n_out != WW * WH || seq_err != 0) $display("FAIL clamp_seq: got %0d outs %0d errors want 30 0", n_out, seq_err); else n_pass++;
        run_frame(7, 7, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 7 || dy != 11 || seq_err != 0) $display("FAIL edge7: got %0d..%0d err %0d want 7..11 err 0", fy, dy, seq_err); else n_pass++;
        run_frame(0, 0, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 0 || dy != 4 || seq_err != 0) $display("FAIL ystart0: got %0d..%0d err %0d want 0..4 err 0", fy, dy, seq_err); else n_pass++;
    endtask

    task automatic test_ystart_change();
        run_frame(3, 1, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 3 || dy != 7 || seq_err != 0) $display("FAIL change_cur: got %0d..%0d err %0d want 3..7 err 0", fy, dy, seq_err); else n_pass++;
        run_frame(1, 1, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 1 || dy != 5 || seq_err != 0) $display("FAIL change_next: got %0d..%0d err %0d want 1..5 err 0", fy, dy, seq_err); else n_pass++;
        n_chk++; if (n_out != WW * WH || n_done != 1) $display("FAIL change_counts: got %0d outs %0d dones want 30 1", n_out, n_done); else n_pass++;
    endtask

    task automatic test_gaps();
        run_frame(3, 3, 1'b1, 1'b0, -1);
        n_chk++; if (n_out != WW * WH || n_done != 1) $display("FAIL gaps_counts: got %0d outs %0d dones want 30 1", n_out, n_done); else n_pass++;
        n_chk++; if (seq_err != 0) $display("FAIL gaps_seq: got %0d errors want 0", seq_err); else n_pass++;
        n_chk++; if (fx != 4 || fy != 3 || dx != 9 || dy != 7) $display("FAIL gaps_pos: got (%0d,%0d)..(%0d,%0d) want (4,3)..(9,7)", fx, fy, dx, dy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_frame(3, 3, 1'b0, 1'b0, 5 * H + 8);
        n_chk++; if (oDVAL !== 1'b1 || oX !== 16'd3 || oY !== 16'd2) $display("FAIL pre_reset: got %b (%0d,%0d) want 1 (3,2)", oDVAL, oX, oY); else n_pass++;
        iDVAL = 1'b0;
        iRST = 1'b0;
        #1;
        n_chk++; if ({oDVAL, oFRAME_DONE, oDATA, oX, oY} !== 44'd0) $display("FAIL async_reset: got %b %b %h %0d %0d want all 0", oDVAL, oFRAME_DONE, oDATA, oX, oY); else n_pass++;
        #2 iRST = 1'b1;
        run_frame(3, 3, 1'b0, 1'b0, -1);
        n_chk++; if (n_out != WW * WH || n_done != 1 || seq_err != 0) $display("FAIL post_reset: got %0d outs %0d dones %0d errors want 30 1 0", n_out, n_done, seq_err); else n_pass++;
        run_frame(2, 2, 1'b0, 1'b0, -1);
        n_chk++; if (fy != 2 || dy != 6 || seq_err != 0) $display("FAIL post_reset_next: got %0d..%0d err %0d want 2..6 err 0", fy, dy, seq_err); else n_pass++;
    endtask

    task automatic test_border();
        run_frame(4, 4, 1'b0, 1'b1, -1);
        n_chk++; if (n_out != WW * WH || seq_err != 0) $display("FAIL border: got %0d outs %0d errors want 30 0", n_out, seq_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_ystart_bounds();
        test_ystart_change();
        test_gaps();
        test_reset_mid();
        test_border();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
